taxi_eth_phy_10g_rx_link_ctrl: RTL and testbench

Link bring-up and recovery sequencer for the 10G MAC/PHY receive path.
- Holds and releases the RX SERDES reset.
- Waits for SERDES ready, then block lock with no high BER, then a stable rx_status window.
- Only then asserts cfg_rx_enable to the MAC RX.
- On timeouts, SERDES reset requests or link loss it re-sequences and counts events. Sits beside the MAC/PHY RX in the per-port wrapper.

---
 rtl/taxi_eth_phy_10g_rx_link_ctrl_if.sv | 32 +++
 rtl/taxi_eth_phy_10g_rx_link_ctrl.sv | 146 ++++++++++++++
 tb/tb_taxi_eth_phy_10g_rx_link_ctrl.sv | 207 ++++++++++++++++++++
 3 files changed

// File: rtl/taxi_eth_phy_10g_rx_link_ctrl_if.sv
// rtl/taxi_eth_phy_10g_rx_link_ctrl_if.sv - RX link controller PHY/SERDES/MAC signal bundle
// master is the link controller; slave is the surrounding PHY/SERDES/MAC side.
interface taxi_eth_phy_10g_rx_link_ctrl_if;
   logic        cfg_link_enable;
   logic        serdes_rx_ready;
   logic        serdes_rx_reset_req;
   logic        rx_block_lock;
   logic        rx_high_ber;
   logic        rx_status;
   logic        serdes_rx_reset;
   logic        cfg_rx_enable;
   logic        link_up;
   logic [2:0]  link_state;
   logic        stat_retry;
   logic        stat_link_down;
   logic [7:0]  retry_count;
   logic [15:0] link_down_count;

   modport master (
      input  cfg_link_enable, serdes_rx_ready, serdes_rx_reset_req,
      input  rx_block_lock, rx_high_ber, rx_status,
      output serdes_rx_reset, cfg_rx_enable, link_up, link_state,
      output stat_retry, stat_link_down, retry_count, link_down_count
   );

   modport slave (
      output cfg_link_enable, serdes_rx_ready, serdes_rx_reset_req,
      output rx_block_lock, rx_high_ber, rx_status,
      input  serdes_rx_reset, cfg_rx_enable, link_up, link_state,
      input  stat_retry, stat_link_down, retry_count, link_down_count
   );
endinterface

// File: rtl/taxi_eth_phy_10g_rx_link_ctrl.sv
// rtl/taxi_eth_phy_10g_rx_link_ctrl.sv - 10G RX link bring-up and recovery sequencer
// One shared down-counter times the SERDES reset, lock timeout and status-stable windows.
module taxi_eth_phy_10g_rx_link_ctrl #(
   parameter int RST_CYCLES    = 16,
   parameter int LOCK_TIMEOUT  = 65536,
   parameter int STABLE_CYCLES = 1024,
   parameter int TIMER_W       = 20
) (
   input  logic clk,
   input  logic rst,
   taxi_eth_phy_10g_rx_link_ctrl_if.master link
);

   typedef enum logic [2:0] {
      ST_DISABLED    = 3'd0,
      ST_SERDES_RST  = 3'd1,
      ST_WAIT_READY  = 3'd2,
      ST_WAIT_LOCK   = 3'd3,
      ST_WAIT_STABLE = 3'd4,
      ST_UP          = 3'd5
   } state_t;

   localparam logic [TIMER_W-1:0] RST_LOAD    = TIMER_W'(RST_CYCLES - 1);
   localparam logic [TIMER_W-1:0] LOCK_LOAD   = TIMER_W'(LOCK_TIMEOUT - 1);
   localparam logic [TIMER_W-1:0] STABLE_LOAD = TIMER_W'(STABLE_CYCLES - 1);

   state_t              state_q, state_d;
   logic [TIMER_W-1:0]  timer_q, timer_d;
   logic                retry_d, link_down_d;
   logic                stat_retry_q, stat_link_down_q;
   logic [7:0]          retry_count_q;
   logic [15:0]         link_down_count_q;
   logic                timer_zero;

   assign timer_zero = (timer_q == '0);

   always_comb begin
      state_d     = state_q;
      timer_d     = timer_q;
      retry_d     = 1'b0;
      link_down_d = 1'b0;

      if (!link.cfg_link_enable) begin
         state_d = ST_DISABLED;
         timer_d = '0;
      end else if (link.serdes_rx_reset_req &&
                   (state_q inside {ST_WAIT_READY, ST_WAIT_LOCK, ST_WAIT_STABLE, ST_UP})) begin
         // PHY-requested reset is a recovery, not a timeout, so it is not a retry
         state_d = ST_SERDES_RST;
         timer_d = RST_LOAD;
      end else begin
         case (state_q)
            ST_DISABLED: begin
               state_d = ST_SERDES_RST;
               timer_d = RST_LOAD;
            end
            ST_SERDES_RST: begin
               if (timer_zero) begin
                  state_d = ST_WAIT_READY;
                  timer_d = LOCK_LOAD;
               end else begin
                  timer_d = timer_q - 1'b1;
               end
            end
            ST_WAIT_READY: begin
               if (link.serdes_rx_ready) begin
                  state_d = ST_WAIT_LOCK;
                  timer_d = LOCK_LOAD;
               end else if (timer_zero) begin
                  state_d = ST_SERDES_RST;
                  timer_d = RST_LOAD;
                  retry_d = 1'b1;
               end else begin
                  timer_d = timer_q - 1'b1;
               end
            end
            ST_WAIT_LOCK: begin
               if (link.rx_block_lock && !link.rx_high_ber) begin
                  state_d = ST_WAIT_STABLE;
                  timer_d = STABLE_LOAD;
               end else if (timer_zero) begin
                  state_d = ST_SERDES_RST;
                  timer_d = RST_LOAD;
                  retry_d = 1'b1;
               end else begin
                  timer_d = timer_q - 1'b1;
               end
            end
            ST_WAIT_STABLE: begin
               if (!link.rx_status) begin
                  state_d = ST_WAIT_LOCK;
                  timer_d = LOCK_LOAD;
               end else if (timer_zero) begin
                  state_d = ST_UP;
               end else begin
                  timer_d = timer_q - 1'b1;
               end
            end
            ST_UP: begin
               if (!link.rx_status) begin
                  state_d = ST_WAIT_LOCK;
                  timer_d = LOCK_LOAD;
               end
            end
            default: begin
               state_d = ST_DISABLED;
               timer_d = '0;
            end
         endcase
      end

      link_down_d = (state_q == ST_UP) && (state_d != ST_UP);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q           <= ST_DISABLED;
         timer_q           <= '0;
         stat_retry_q      <= 1'b0;
         stat_link_down_q  <= 1'b0;
         retry_count_q     <= '0;
         link_down_count_q <= '0;
      end else begin
         state_q          <= state_d;
         timer_q          <= timer_d;
         stat_retry_q     <= retry_d;
         stat_link_down_q <= link_down_d;
         if (retry_d && (retry_count_q != 8'hFF)) begin
            retry_count_q <= retry_count_q + 8'd1;
         end
         if (link_down_d && (link_down_count_q != 16'hFFFF)) begin
            link_down_count_q <= link_down_count_q + 16'd1;
         end
      end
   end

   assign link.serdes_rx_reset = (state_q == ST_DISABLED) || (state_q == ST_SERDES_RST);
   assign link.cfg_rx_enable   = (state_q == ST_UP);
   assign link.link_up         = (state_q == ST_UP);
   assign link.link_state      = state_q;
   assign link.stat_retry      = stat_retry_q;
   assign link.stat_link_down  = stat_link_down_q;
   assign link.retry_count     = retry_count_q;
   assign link.link_down_count = link_down_count_q;

endmodule

// File: tb/tb_taxi_eth_phy_10g_rx_link_ctrl.sv
// tb/tb_taxi_eth_phy_10g_rx_link_ctrl.sv - directed bench for the RX link controller
// Instance a: 4/32/8 timing; instance b: LOCK_TIMEOUT=1 for retry counter saturation.
module tb_taxi_eth_phy_10g_rx_link_ctrl;

   logic clk = 1'b0;
   logic rst_a;
   logic rst_b;
   int   total = 0;
   int   bad   = 0;

   always #5 clk = ~clk;

   taxi_eth_phy_10g_rx_link_ctrl_if la ();
   taxi_eth_phy_10g_rx_link_ctrl_if lb ();

   taxi_eth_phy_10g_rx_link_ctrl #(
      .RST_CYCLES(4), .LOCK_TIMEOUT(32), .STABLE_CYCLES(8), .TIMER_W(20)
   ) dut_a (
      .clk(clk), .rst(rst_a), .link(la)
   );

   taxi_eth_phy_10g_rx_link_ctrl #(
      .RST_CYCLES(4), .LOCK_TIMEOUT(1), .STABLE_CYCLES(8), .TIMER_W(20)
   ) dut_b (
      .clk(clk), .rst(rst_b), .link(lb)
   );

   task automatic step(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic wait_state(input bit sel_b, input logic [2:0] s, input int lim);
      int n;
      n = 0;
      while (((sel_b ? lb.link_state : la.link_state) !== s) && (n < lim)) begin
         step(1);
         n++;
      end
      chk("wait_state", sel_b ? lb.link_state : la.link_state, s);
   endtask

   task automatic chk_reset_vals(input bit sel_b);
      if (sel_b) begin
         chk("b_rst_state", lb.link_state, 3'd0);
         chk("b_rst_serdes_rst", lb.serdes_rx_reset, 1'b1);
         chk("b_rst_rx_en", lb.cfg_rx_enable, 1'b0);
         chk("b_rst_link_up", lb.link_up, 1'b0);
         chk("b_rst_stat_retry", lb.stat_retry, 1'b0);
         chk("b_rst_stat_down", lb.stat_link_down, 1'b0);
         chk("b_rst_retry_cnt", lb.retry_count, 8'd0);
         chk("b_rst_down_cnt", lb.link_down_count, 16'd0);
      end else begin
         chk("a_rst_state", la.link_state, 3'd0);
         chk("a_rst_serdes_rst", la.serdes_rx_reset, 1'b1);
         chk("a_rst_rx_en", la.cfg_rx_enable, 1'b0);
         chk("a_rst_link_up", la.link_up, 1'b0);
         chk("a_rst_stat_retry", la.stat_retry, 1'b0);
         chk("a_rst_stat_down", la.stat_link_down, 1'b0);
         chk("a_rst_retry_cnt", la.retry_count, 8'd0);
         chk("a_rst_down_cnt", la.link_down_count, 16'd0);
      end
   endtask

   initial begin
      rst_a = 1'b1;
      rst_b = 1'b1;
      la.cfg_link_enable = 0; la.serdes_rx_ready = 0; la.serdes_rx_reset_req = 0;
      la.rx_block_lock = 0; la.rx_high_ber = 0; la.rx_status = 0;
      lb.cfg_link_enable = 0; lb.serdes_rx_ready = 0; lb.serdes_rx_reset_req = 0;
      lb.rx_block_lock = 0; lb.rx_high_ber = 0; lb.rx_status = 0;
      step(2);
      chk_reset_vals(1'b0);
      chk_reset_vals(1'b1);
      rst_a = 1'b0;
      rst_b = 1'b0;
      step(1);
      chk("a_disabled_hold", la.link_state, 3'd0);

      // 1: clean bring-up
      la.cfg_link_enable = 1; la.serdes_rx_ready = 1; la.rx_block_lock = 1; la.rx_status = 1;
      step(1);
      for (int i = 0; i < 4; i++) begin
         chk("t1_serdes_rst_state", la.link_state, 3'd1);
         chk("t1_serdes_rst_out", la.serdes_rx_reset, 1'b1);
         step(1);
      end
      chk("t1_wait_ready", la.link_state, 3'd2);
      chk("t1_serdes_rst_released", la.serdes_rx_reset, 1'b0);
      step(1);
      chk("t1_wait_lock", la.link_state, 3'd3);
      step(1);
      for (int i = 0; i < 8; i++) begin
         chk("t1_wait_stable", la.link_state, 3'd4);
         chk("t1_rx_en_low", la.cfg_rx_enable, 1'b0);
         step(1);
      end
      chk("t1_up_state", la.link_state, 3'd5);
      chk("t1_rx_en", la.cfg_rx_enable, 1'b1);
      chk("t1_link_up", la.link_up, 1'b1);

      // 4: status loss in UP, then PHY reset request
      la.rx_status = 0;
      step(1);
      chk("t4_state", la.link_state, 3'd3);
      chk("t4_rx_en", la.cfg_rx_enable, 1'b0);
      chk("t4_stat_down", la.stat_link_down, 1'b1);
      chk("t4_down_cnt", la.link_down_count, 16'd1);
      la.rx_status = 1;
      la.serdes_rx_reset_req = 1;
      step(1);
      la.serdes_rx_reset_req = 0;
      chk("t4_req_state", la.link_state, 3'd1);
      chk("t4_req_no_retry", la.stat_retry, 1'b0);
      chk("t4_req_retry_cnt", la.retry_count, 8'd0);
      chk("t4_stat_down_single", la.stat_link_down, 1'b0);

      // 3: one-cycle status drop at stable cycle 5
      wait_state(1'b0, 3'd4, 20);
      step(4);
      chk("t3_still_stable", la.link_state, 3'd4);
      la.rx_status = 0;
      step(1);
      chk("t3_back_to_lock", la.link_state, 3'd3);
      la.rx_status = 1;
      step(1);
      for (int i = 0; i < 8; i++) begin
         chk("t3_restable", la.link_state, 3'd4);
         step(1);
      end
      chk("t3_up", la.link_state, 3'd5);

      // 5: enable and status drop together
      la.cfg_link_enable = 0;
      la.rx_status = 0;
      step(1);
      chk("t5_state", la.link_state, 3'd0);
      chk("t5_serdes_rst", la.serdes_rx_reset, 1'b1);
      chk("t5_stat_down", la.stat_link_down, 1'b1);
      chk("t5_down_cnt", la.link_down_count, 16'd2);
      step(1);
      chk("t5_stat_down_off", la.stat_link_down, 1'b0);
      chk("t5_down_cnt_hold", la.link_down_count, 16'd2);

      // 2: ready never arrives
      la.cfg_link_enable = 1;
      la.serdes_rx_ready = 0;
      la.rx_status = 1;
      step(1);
      chk("t2_serdes_rst", la.link_state, 3'd1);
      step(4);
      for (int i = 0; i < 32; i++) begin
         chk("t2_wait_ready", la.link_state, 3'd2);
         chk("t2_no_retry_yet", la.stat_retry, 1'b0);
         step(1);
      end
      chk("t2_retry_state", la.link_state, 3'd1);
      chk("t2_stat_retry", la.stat_retry, 1'b1);
      chk("t2_retry_cnt1", la.retry_count, 8'd1);
      step(1);
      chk("t2_stat_retry_off", la.stat_retry, 1'b0);
      step(35);
      chk("t2_retry2_state", la.link_state, 3'd1);
      chk("t2_stat_retry2", la.stat_retry, 1'b1);
      chk("t2_retry_cnt2", la.retry_count, 8'd2);

      // high BER holds WAIT_LOCK even with block lock
      la.serdes_rx_ready = 1;
      la.rx_high_ber = 1;
      wait_state(1'b0, 3'd3, 20);
      step(1);
      chk("ber_hold", la.link_state, 3'd3);
      la.rx_high_ber = 0;
      step(1);
      chk("ber_clear", la.link_state, 3'd4);

      // 6: retry counter saturation and reset mid-sequence
      lb.cfg_link_enable = 1;
      step(1 + 5 * 255);
      chk("t6_retry_cnt_255", lb.retry_count, 8'd255);
      chk("t6_stat_retry", lb.stat_retry, 1'b1);
      step(5);
      chk("t6_sat_state", lb.link_state, 3'd1);
      chk("t6_sat_stat_retry", lb.stat_retry, 1'b1);
      chk("t6_retry_cnt_sat", lb.retry_count, 8'd255);
      lb.serdes_rx_ready = 1;
      wait_state(1'b1, 3'd3, 20);
      rst_b = 1'b1;
      step(1);
      chk_reset_vals(1'b1);
      rst_b = 1'b0;

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
